// File: rtl/norm_ctrl_pkg.sv
// Shared types and constants for the linked-list norm sequencer:
// FSM state encoding, norm mode codes and read-latency limits.
package norm_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    ACCUM = 3'd4,
    DONE  = 3'd5,
    OVF   = 3'd6
  } state_t;

  localparam logic [1:0] MODE_L1   = 2'd0;
  localparam logic [1:0] MODE_L2   = 2'd1;
  localparam logic [1:0] MODE_LINF = 2'd2;

  localparam int MEM_LAT_MAX  = 4;
  localparam int LAT_CNT_BITS = $clog2(MEM_LAT_MAX);

  // The reserved code 3 behaves as L2 so the datapath only ever sees legal modes.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return ((m == MODE_L1) || (m == MODE_LINF)) ? m : MODE_L2;
  endfunction

endpackage

// File: rtl/norm_list_sequencer_if.sv
// Memory read port and accumulator control between the sequencer (master)
// and the memory/accumulator datapath (slave).
interface norm_list_sequencer_if #(
  parameter int ADDR_BITS = 9
);
  logic                 mem_rd;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [ADDR_BITS-1:0] mem_rnext;
  logic                 acc_clr;
  logic                 acc_en;
  logic [1:0]           acc_mode;

  modport master (
    output mem_rd, mem_addr, acc_clr, acc_en, acc_mode,
    input  mem_rnext
  );

  modport slave (
    input  mem_rd, mem_addr, acc_clr, acc_en, acc_mode,
    output mem_rnext
  );
endinterface

// File: rtl/norm_lat_timer.sv
// Loadable down-counter that holds the sequencer in WAIT until the memory
// read data is due; zero is high once the count has run out.
module norm_lat_timer #(
  parameter int CNT_BITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [CNT_BITS-1:0] load_val,
  output logic                zero
);

  logic [CNT_BITS-1:0] cnt_reg;
  logic [CNT_BITS-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (load) begin
      cnt_next = load_val;
    end else if (cnt_reg != '0) begin
      cnt_next = cnt_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/norm_list_sequencer.sv
// Walks a vector stored as a linked list: one fixed-latency read per node,
// drives accumulator clear/enable, counts elements, reports done or overflow.
module norm_list_sequencer
  import norm_ctrl_pkg::*;
#(
  parameter int WORD_SIZE = 24,
  parameter int ADDR_BITS = 9,
  parameter int LEN_BITS  = 8,
  parameter int MEM_LAT   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [ADDR_BITS-1:0] head_addr,
  input  logic [1:0]           mode,
  norm_list_sequencer_if.master bus,
  output logic [LEN_BITS-1:0]  length,
  output logic                 busy,
  output logic                 done,
  output logic                 result_valid,
  output logic                 err_overflow,
  output logic [2:0]           state
);

  if ((MEM_LAT < 1) || (MEM_LAT > MEM_LAT_MAX) || (WORD_SIZE < 1) || (LEN_BITS < 2)) begin : g_param_check
    $error("norm_list_sequencer: unsupported parameter combination");
  end

  // Pre-increment length at which the next element would reach the maximum.
  localparam logic [LEN_BITS-1:0] LEN_LAST = {{(LEN_BITS-1){1'b1}}, 1'b0};
  // ISSUE itself covers one latency cycle and WAIT exits on zero, hence MEM_LAT-2.
  localparam logic [LAT_CNT_BITS-1:0] LAT_LOAD =
    (MEM_LAT >= 2) ? LAT_CNT_BITS'(MEM_LAT - 2) : '0;

  state_t               state_reg, state_next;
  logic [ADDR_BITS-1:0] ptr_reg, ptr_next;
  logic [LEN_BITS-1:0]  length_reg, length_next;
  logic [1:0]           mode_reg, mode_next;
  logic                 result_valid_reg, result_valid_next;
  logic                 err_overflow_reg, err_overflow_next;
  logic                 timer_load;
  logic                 timer_zero;

  norm_lat_timer #(
    .CNT_BITS (LAT_CNT_BITS)
  ) u_lat_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (LAT_LOAD),
    .zero     (timer_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      ptr_reg          <= '0;
      length_reg       <= '0;
      mode_reg         <= '0;
      result_valid_reg <= 1'b0;
      err_overflow_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      ptr_reg          <= ptr_next;
      length_reg       <= length_next;
      mode_reg         <= mode_next;
      result_valid_reg <= result_valid_next;
      err_overflow_reg <= err_overflow_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    ptr_next          = ptr_reg;
    length_next       = length_reg;
    mode_next         = mode_reg;
    result_valid_next = result_valid_reg;
    err_overflow_next = err_overflow_reg;
    timer_load        = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (start) begin
          mode_next         = norm_mode(mode);
          ptr_next          = head_addr;
          result_valid_next = 1'b0;
          err_overflow_next = 1'b0;
          state_next        = CLEAR;
        end
      end
      CLEAR: begin
        length_next = '0;
        state_next  = ISSUE;
      end
      ISSUE: begin
        timer_load = 1'b1;
        state_next = (MEM_LAT == 1) ? ACCUM : WAIT;
      end
      WAIT: begin
        if (timer_zero) begin
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        length_next = length_reg + 1'b1;
        ptr_next    = bus.mem_rnext;
        if (bus.mem_rnext == '0) begin
          state_next = DONE;
        end else if (length_reg == LEN_LAST) begin
          state_next = OVF;
        end else begin
          state_next = ISSUE;
        end
      end
      DONE: begin
        result_valid_next = 1'b1;
        state_next        = IDLE;
      end
      OVF: begin
        err_overflow_next = 1'b1;
        state_next        = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Abort overrides every transition and suppresses the sticky completion flags.
    if (abort && (state_reg != IDLE)) begin
      state_next        = IDLE;
      result_valid_next = 1'b0;
      err_overflow_next = err_overflow_reg;
    end
  end

  assign bus.mem_rd   = (state_reg == ISSUE);
  assign bus.mem_addr = (state_reg == ISSUE) ? ptr_reg : '0;
  assign bus.acc_clr  = (state_reg == CLEAR);
  assign bus.acc_en   = (state_reg == ACCUM);
  assign bus.acc_mode = mode_reg;

  assign length       = length_reg;
  assign busy         = (state_reg != IDLE);
  assign done         = (state_reg == DONE) || (state_reg == OVF);
  assign result_valid = result_valid_reg;
  assign err_overflow = err_overflow_reg;
  assign state        = state_reg;

endmodule

// File: tb/tb_norm_list_sequencer.sv
// Bench for norm_list_sequencer: three instances (latency 1, latency 3, 3-bit length)
// sharing one linked-list memory; reads and completions are scoreboarded.
module tb_norm_list_sequencer;
  import norm_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start_a, start_b, start_c;
  logic       abort_a, abort_b, abort_c;
  logic [8:0] head_a, head_b, head_c;
  logic [1:0] mode_a, mode_b, mode_c;
  logic [7:0] length_a, length_b;
  logic [2:0] length_c;
  logic       busy_a, busy_b, busy_c;
  logic       done_a, done_b, done_c;
  logic       rv_a, rv_b, rv_c;
  logic       ovf_a, ovf_b, ovf_c;
  logic [2:0] state_a, state_b, state_c;

  norm_list_sequencer_if #(.ADDR_BITS(9)) bus_a ();
  norm_list_sequencer_if #(.ADDR_BITS(9)) bus_b ();
  norm_list_sequencer_if #(.ADDR_BITS(9)) bus_c ();

  norm_list_sequencer #(.WORD_SIZE(24), .ADDR_BITS(9), .LEN_BITS(8), .MEM_LAT(1)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .head_addr(head_a), .mode(mode_a),
    .bus(bus_a.master), .length(length_a), .busy(busy_a), .done(done_a),
    .result_valid(rv_a), .err_overflow(ovf_a), .state(state_a));

  norm_list_sequencer #(.WORD_SIZE(24), .ADDR_BITS(9), .LEN_BITS(8), .MEM_LAT(3)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .head_addr(head_b), .mode(mode_b),
    .bus(bus_b.master), .length(length_b), .busy(busy_b), .done(done_b),
    .result_valid(rv_b), .err_overflow(ovf_b), .state(state_b));

  norm_list_sequencer #(.WORD_SIZE(24), .ADDR_BITS(9), .LEN_BITS(3), .MEM_LAT(1)) u_dut_c (
    .clk(clk), .rst(rst), .start(start_c), .abort(abort_c), .head_addr(head_c), .mode(mode_c),
    .bus(bus_c.master), .length(length_c), .busy(busy_c), .done(done_c),
    .result_valid(rv_c), .err_overflow(ovf_c), .state(state_c));

  // Next-pointer memory with per-instance read latency pipelines.
  logic [8:0] next_mem [0:511];
  logic [8:0] pipe_a = '0;
  logic [8:0] pipe_c = '0;
  logic [8:0] pipe_b [3] = '{default: '0};

  always @(posedge clk) begin
    pipe_a    <= bus_a.mem_addr;
    pipe_c    <= bus_c.mem_addr;
    pipe_b[0] <= bus_b.mem_addr;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end

  assign bus_a.mem_rnext = next_mem[pipe_a];
  assign bus_b.mem_rnext = next_mem[pipe_b[2]];
  assign bus_c.mem_rnext = next_mem[pipe_c];

  logic [2:0] rd_v, en_v, done_v;
  logic [8:0] addr_v [3];
  logic [7:0] len_v [3];
  logic [2:0] state_v [3];
  assign rd_v   = {bus_c.mem_rd, bus_b.mem_rd, bus_a.mem_rd};
  assign en_v   = {bus_c.acc_en, bus_b.acc_en, bus_a.acc_en};
  assign done_v = {done_c, done_b, done_a};
  assign addr_v[0] = bus_a.mem_addr;
  assign addr_v[1] = bus_b.mem_addr;
  assign addr_v[2] = bus_c.mem_addr;
  assign len_v[0] = length_a;
  assign len_v[1] = length_b;
  assign len_v[2] = {5'd0, length_c};
  assign state_v[0] = state_a;
  assign state_v[1] = state_b;
  assign state_v[2] = state_c;

  typedef struct { int id; int addr; } rd_exp_t;
  typedef struct { int id; int cyc; int len; } done_exp_t;
  rd_exp_t   rd_q[$];
  done_exp_t done_q[$];
  rd_exp_t   rd_e;
  done_exp_t dn_e;

  int ncyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  int en_cnt [3] = '{0, 0, 0};
  int done_cnt [3] = '{0, 0, 0};
  int wait_cnt [3] = '{0, 0, 0};

  // Scoreboard monitor: every read and every done pulse is matched against the queues.
  always @(negedge clk) begin
    ncyc = ncyc + 1;
    for (int k = 0; k < 3; k++) begin
      if (rd_v[k]) begin
        n_checks++;
        if (rd_q.size() == 0) begin
          $display("FAIL rd_unexpected dut=%0d got addr=%0d want no read", k, addr_v[k]);
        end else begin
          rd_e = rd_q.pop_front();
          if ((rd_e.id !== k) || (rd_e.addr !== int'(addr_v[k])))
            $display("FAIL rd_addr got dut=%0d addr=%0d want dut=%0d addr=%0d", k, addr_v[k], rd_e.id, rd_e.addr);
          else begin
            n_pass++;
            $display("rd   dut=%0d cyc=%0d addr=%0d", k, ncyc, addr_v[k]);
          end
        end
      end
      if (done_v[k]) begin
        done_cnt[k]++;
        n_checks++;
        if (done_q.size() == 0) begin
          $display("FAIL done_unexpected dut=%0d cyc=%0d want no done", k, ncyc);
        end else begin
          dn_e = done_q.pop_front();
          if ((dn_e.id !== k) || (dn_e.cyc !== ncyc) || (dn_e.len !== int'(len_v[k])))
            $display("FAIL done got dut=%0d cyc=%0d len=%0d want dut=%0d cyc=%0d len=%0d",
                     k, ncyc, len_v[k], dn_e.id, dn_e.cyc, dn_e.len);
          else begin
            n_pass++;
            $display("done dut=%0d cyc=%0d len=%0d", k, ncyc, len_v[k]);
          end
        end
      end
      if (en_v[k]) en_cnt[k]++;
      if (state_v[k] == 3'(WAIT)) wait_cnt[k]++;
    end
  end

  // Reference walk: follows the memory and queues expected reads and the completion.
  task automatic expect_walk(input int k, input int head, input int lat, input int maxlen);
    int addr;
    int cnt;
    int nxt;
    rd_exp_t r;
    done_exp_t d;
    addr = head;
    cnt  = 0;
    for (int i = 0; i < 1000; i++) begin
      r.id = k;
      r.addr = addr;
      rd_q.push_back(r);
      cnt++;
      nxt = int'(next_mem[addr]);
      if (nxt == 0) break;
      if (cnt == maxlen) break;
      addr = nxt;
    end
    d.id  = k;
    d.cyc = ncyc + 1 + 2 + cnt * (lat + 1);
    d.len = cnt;
    done_q.push_back(d);
  endtask

  task automatic push_rd(input int k, input int addr);
    rd_exp_t r;
    r.id = k;
    r.addr = addr;
    rd_q.push_back(r);
  endtask

  task automatic pulse_start(input int k, input logic [8:0] head, input logic [1:0] m);
    case (k)
      0: begin start_a = 1'b1; head_a = head; mode_a = m; end
      1: begin start_b = 1'b1; head_b = head; mode_b = m; end
      default: begin start_c = 1'b1; head_c = head; mode_c = m; end
    endcase
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
  endtask

  task automatic wait_done(input int k, input int budget, output bit ok);
    int base;
    base = done_cnt[k];
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (done_cnt[k] != base) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy_a, done_a, rv_a, ovf_a, length_a, state_a, bus_a.mem_rd, bus_a.mem_addr,
         bus_a.acc_clr, bus_a.acc_en, bus_a.acc_mode} !== '0)
      $display("FAIL reset_outputs_a got nonzero outputs want all 0");
    else n_pass++;
    n_checks++;
    if ({busy_b, done_b, rv_b, ovf_b, length_b, state_b, bus_b.mem_rd, bus_b.mem_addr,
         bus_b.acc_clr, bus_b.acc_en, bus_b.acc_mode} !== '0)
      $display("FAIL reset_outputs_b got nonzero outputs want all 0");
    else n_pass++;
    n_checks++;
    if ({busy_c, done_c, rv_c, ovf_c, length_c, state_c, bus_c.mem_rd, bus_c.mem_addr,
         bus_c.acc_clr, bus_c.acc_en, bus_c.acc_mode} !== '0)
      $display("FAIL reset_outputs_c got nonzero outputs want all 0");
    else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_l2_walk;
    bit ok;
    int base_en;
    base_en = en_cnt[0];
    expect_walk(0, 5, 1, 255);
    pulse_start(0, 9'd5, 2'd1);
    wait_done(0, 60, ok);
    n_checks++;
    if (!ok) $display("FAIL l2_walk_timeout got no done want done"); else n_pass++;
    n_checks++;
    if (rv_a !== 1'b1 || ovf_a !== 1'b0)
      $display("FAIL l2_walk_flags got rv=%0b ovf=%0b want rv=1 ovf=0", rv_a, ovf_a);
    else n_pass++;
    n_checks++;
    if (bus_a.acc_mode !== 2'd1) $display("FAIL l2_walk_mode got %0d want 1", bus_a.acc_mode); else n_pass++;
    n_checks++;
    if (length_a !== 8'd3) $display("FAIL l2_walk_length got %0d want 3", length_a); else n_pass++;
    n_checks++;
    if (en_cnt[0] - base_en !== 3) $display("FAIL l2_walk_acc_en got %0d want 3", en_cnt[0] - base_en); else n_pass++;
  endtask

  task automatic test_lat3_single;
    bit ok;
    int base_wait;
    int base_en;
    base_wait = wait_cnt[1];
    base_en = en_cnt[1];
    expect_walk(1, 0, 3, 255);
    pulse_start(1, 9'd0, 2'd0);
    wait_done(1, 60, ok);
    n_checks++;
    if (!ok) $display("FAIL lat3_timeout got no done want done"); else n_pass++;
    n_checks++;
    if (wait_cnt[1] - base_wait !== 2) $display("FAIL lat3_wait_cycles got %0d want 2", wait_cnt[1] - base_wait); else n_pass++;
    n_checks++;
    if (en_cnt[1] - base_en !== 1) $display("FAIL lat3_acc_en got %0d want 1", en_cnt[1] - base_en); else n_pass++;
    n_checks++;
    if (length_b !== 8'd1 || rv_b !== 1'b1)
      $display("FAIL lat3_result got len=%0d rv=%0b want len=1 rv=1", length_b, rv_b);
    else n_pass++;
  endtask

  task automatic test_overflow;
    bit ok;
    int base_en;
    base_en = en_cnt[2];
    expect_walk(2, 100, 1, 7);
    pulse_start(2, 9'd100, 2'd2);
    wait_done(2, 80, ok);
    n_checks++;
    if (!ok) $display("FAIL ovf_timeout got no done want done"); else n_pass++;
    n_checks++;
    if (ovf_c !== 1'b1 || rv_c !== 1'b0)
      $display("FAIL ovf_flags got ovf=%0b rv=%0b want ovf=1 rv=0", ovf_c, rv_c);
    else n_pass++;
    n_checks++;
    if (length_c !== 3'd7) $display("FAIL ovf_length got %0d want 7", length_c); else n_pass++;
    n_checks++;
    if (en_cnt[2] - base_en !== 7) $display("FAIL ovf_acc_en got %0d want 7", en_cnt[2] - base_en); else n_pass++;
  endtask

  task automatic test_self_loop;
    bit ok;
    expect_walk(2, 200, 1, 7);
    pulse_start(2, 9'd200, 2'd0);
    n_checks++;
    if (ovf_c !== 1'b0) $display("FAIL self_loop_ovf_clear got %0b want 0", ovf_c); else n_pass++;
    wait_done(2, 80, ok);
    n_checks++;
    if (!ok || ovf_c !== 1'b1 || rv_c !== 1'b0)
      $display("FAIL self_loop_end got done=%0b ovf=%0b rv=%0b want done=1 ovf=1 rv=0", ok, ovf_c, rv_c);
    else n_pass++;
  endtask

  task automatic test_abort;
    bit ok;
    int base_done;
    int base_en;
    base_done = done_cnt[1];
    base_en = en_cnt[1];
    push_rd(1, 20);
    push_rd(1, 21);
    pulse_start(1, 9'd20, 2'd1);
    repeat (6) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if (state_b !== 3'(WAIT)) $display("FAIL abort_pre_state got %0d want %0d", state_b, 3'(WAIT)); else n_pass++;
    abort_b = 1'b1;
    @(posedge clk); #1;
    abort_b = 1'b0;
    n_checks++;
    if (state_b !== 3'(IDLE) || busy_b !== 1'b0)
      $display("FAIL abort_idle got state=%0d busy=%0b want state=0 busy=0", state_b, busy_b);
    else n_pass++;
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (done_cnt[1] !== base_done || rv_b !== 1'b0)
      $display("FAIL abort_no_done got dones=%0d rv=%0b want dones=0 rv=0", done_cnt[1] - base_done, rv_b);
    else n_pass++;
    n_checks++;
    if (en_cnt[1] - base_en !== 1) $display("FAIL abort_acc_en got %0d want 1", en_cnt[1] - base_en); else n_pass++;
    expect_walk(1, 20, 3, 255);
    pulse_start(1, 9'd20, 2'd1);
    n_checks++;
    if (bus_b.acc_clr !== 1'b1) $display("FAIL restart_clr got %0b want 1", bus_b.acc_clr); else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (length_b !== 8'd0) $display("FAIL restart_length got %0d want 0", length_b); else n_pass++;
    wait_done(1, 60, ok);
    n_checks++;
    if (!ok || rv_b !== 1'b1 || length_b !== 8'd3)
      $display("FAIL restart_result got done=%0b rv=%0b len=%0d want done=1 rv=1 len=3", ok, rv_b, length_b);
    else n_pass++;
  endtask

  task automatic test_start_ignored;
    bit ok;
    expect_walk(0, 5, 1, 255);
    pulse_start(0, 9'd5, 2'd1);
    start_a = 1'b1;
    head_a = 9'd30;
    mode_a = 2'd0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    start_a = 1'b0;
    wait_done(0, 60, ok);
    n_checks++;
    if (!ok || bus_a.acc_mode !== 2'd1)
      $display("FAIL start_ignored got done=%0b mode=%0d want done=1 mode=1", ok, bus_a.acc_mode);
    else n_pass++;
  endtask

  task automatic test_rst_mid_walk;
    push_rd(0, 5);
    pulse_start(0, 9'd5, 2'd2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if ({busy_a, done_a, rv_a, ovf_a, length_a, state_a, bus_a.mem_rd, bus_a.mem_addr,
         bus_a.acc_clr, bus_a.acc_en, bus_a.acc_mode} !== '0)
      $display("FAIL rst_mid_walk got busy=%0b len=%0d state=%0d mode=%0d want all 0",
               busy_a, length_a, state_a, bus_a.acc_mode);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_mode;
    logic [1:0] mode_in [3]  = '{2'd3, 2'd0, 2'd2};
    logic [1:0] mode_exp [3] = '{2'd1, 2'd0, 2'd2};
    bit ok;
    for (int i = 0; i < 3; i++) begin
      expect_walk(0, 40, 1, 255);
      pulse_start(0, 9'd40, mode_in[i]);
      mode_a = ~mode_in[i];
      wait_done(0, 40, ok);
      n_checks++;
      if (!ok || bus_a.acc_mode !== mode_exp[i])
        $display("FAIL mode_latch in=%0d got done=%0b mode=%0d want done=1 mode=%0d",
                 mode_in[i], ok, bus_a.acc_mode, mode_exp[i]);
      else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1;
    {start_a, start_b, start_c, abort_a, abort_b, abort_c} = '0;
    {head_a, head_b, head_c} = '0;
    {mode_a, mode_b, mode_c} = '0;
    for (int i = 0; i < 512; i++) next_mem[i] = 9'd0;
    next_mem[5]  = 9'd9;
    next_mem[9]  = 9'd12;
    next_mem[12] = 9'd0;
    next_mem[20] = 9'd21;
    next_mem[21] = 9'd22;
    next_mem[22] = 9'd0;
    next_mem[30] = 9'd0;
    next_mem[40] = 9'd0;
    for (int i = 100; i < 108; i++) next_mem[i] = 9'(i + 1);
    next_mem[108] = 9'd0;
    next_mem[200] = 9'd200;

    test_reset();
    test_l2_walk();
    test_lat3_single();
    test_overflow();
    test_self_loop();
    test_abort();
    test_start_ignored();
    test_mode();
    test_rst_mid_walk();

    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (rd_q.size() != 0 || done_q.size() != 0)
      $display("FAIL pending_expectations got reads=%0d dones=%0d want 0 0", rd_q.size(), done_q.size());
    else n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
